// File: rtl/kernel_seq_pkg.sv
// rtl/kernel_seq_pkg.sv - shared types and constants for the kernel run sequencer
package kernel_seq_pkg;

    localparam int KSEQ_INF_W = 4;

    typedef enum logic [1:0] {
        KSEQ_IDLE  = 2'd0,
        KSEQ_RUN   = 2'd1,
        KSEQ_DRAIN = 2'd2,
        KSEQ_FAULT = 2'd3
    } kseq_state_e;

endpackage

// File: rtl/kernel_run_sequencer_if.sv
// rtl/kernel_run_sequencer_if.sv - ap_ctrl_hs block-level handshake between sequencer and kernel
interface kernel_run_sequencer_if;

    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_idle;

    modport master (
        output ap_start,
        input  ap_ready,
        input  ap_done,
        input  ap_idle
    );

    modport slave (
        input  ap_start,
        output ap_ready,
        output ap_done,
        output ap_idle
    );

endinterface

// File: rtl/kernel_seq_ts_fifo.sv
// rtl/kernel_seq_ts_fifo.sv - start-timestamp FIFO, one entry per run in flight
module kernel_seq_ts_fifo
    import kernel_seq_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 24
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [W-1:0]          din,
    output logic [W-1:0]          dout,
    output logic [KSEQ_INF_W-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]          mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [KSEQ_INF_W-1:0] cnt;
    logic                  do_pop;
    logic                  do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A pop in the same cycle frees a slot, so a full FIFO can still take the push.
    always_comb begin
        do_pop  = pop && (cnt != '0);
        do_push = push && ((cnt != KSEQ_INF_W'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (do_push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_push && !do_pop)
                cnt <= cnt + KSEQ_INF_W'(1);
            else if (do_pop && !do_push)
                cnt <= cnt - KSEQ_INF_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/kernel_run_sequencer.sv
// rtl/kernel_run_sequencer.sv - issues N ap_ctrl_hs kernel runs per command; optional KERNEL_SEQ_LAT_STATS_EN latency stats
module kernel_run_sequencer
    import kernel_seq_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int MAX_INFLIGHT   = 2,
    parameter int LAT_W          = 24,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CNT_W-1:0]      cmd_runs,
    input  logic                  abort,
    kernel_run_sequencer_if.master ap,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic                  seq_error,
    output logic [CNT_W-1:0]      runs_issued,
    output logic [CNT_W-1:0]      runs_done,
    output logic [KSEQ_INF_W-1:0] inflight,
    output logic [LAT_W-1:0]      last_lat,
    output logic [LAT_W-1:0]      max_lat
);

    localparam logic [KSEQ_INF_W-1:0] INF_MAX = KSEQ_INF_W'(MAX_INFLIGHT);
    localparam logic [LAT_W-1:0]      TO_LAST = LAT_W'(TIMEOUT_CYCLES - 1);

    kseq_state_e           state, state_nxt;
    logic [CNT_W-1:0]      target;
    logic [CNT_W-1:0]      issued_q, issued_nxt;
    logic [CNT_W-1:0]      done_q, done_nxt;
    logic [KSEQ_INF_W-1:0] inflight_q, inflight_nxt;
    logic [LAT_W-1:0]      to_cnt;
    logic                  start_q, start_nxt;
    logic                  seq_done_q, seq_done_nxt;
    logic                  abort_q;
    logic                  hs, dn, spurious, to_expire;
    logic                  abort_eff, go_drain, finish, accept, live;

    always_comb begin
        hs        = start_q && ap.ap_ready;
        dn        = ap.ap_done;
        live      = (state == KSEQ_RUN) || (state == KSEQ_DRAIN);
        spurious  = dn && (inflight_q == '0) && !hs;
        to_expire = (inflight_q != '0) && !dn && (to_cnt == TO_LAST);
        accept    = (state == KSEQ_IDLE) && cmd_valid && !spurious;
        abort_eff = abort || abort_q;

        issued_nxt = (hs && issued_q != '1) ? issued_q + CNT_W'(1) : issued_q;
        done_nxt   = (dn && !spurious && done_q != '1) ? done_q + CNT_W'(1) : done_q;

        inflight_nxt = inflight_q;
        if (hs && !dn && inflight_q < INF_MAX)
            inflight_nxt = inflight_q + KSEQ_INF_W'(1);
        else if (!hs && dn && inflight_q != '0)
            inflight_nxt = inflight_q - KSEQ_INF_W'(1);

        // A start already on the bus must complete its handshake before draining.
        go_drain = (issued_nxt == target) || (abort_eff && (!start_q || hs));
        finish   = (((state == KSEQ_DRAIN) && !seq_done_q) || ((state == KSEQ_RUN) && go_drain))
                   && (inflight_nxt == '0) && ap.ap_idle;
    end

    always_ff @(posedge clock) begin
        if (!reset)
            state <= KSEQ_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state != KSEQ_FAULT && (spurious || to_expire)) begin
            state_nxt = KSEQ_FAULT;
        end else begin
            case (state)
                KSEQ_IDLE:  if (cmd_valid) state_nxt = (cmd_runs == '0) ? KSEQ_DRAIN : KSEQ_RUN;
                KSEQ_RUN:   if (go_drain)  state_nxt = KSEQ_DRAIN;
                KSEQ_DRAIN: if (seq_done_q) state_nxt = KSEQ_IDLE;
                default:    state_nxt = KSEQ_FAULT;
            endcase
        end
    end

    // Next values for the registered outputs; next-cycle counts allow back-to-back starts.
    always_comb begin
        start_nxt    = 1'b0;
        seq_done_nxt = 1'b0;
        case (state)
            KSEQ_IDLE: start_nxt = cmd_valid && (cmd_runs != '0) && !abort;
            KSEQ_RUN: begin
                start_nxt    = (start_q && !ap.ap_ready)
                               || (!abort_eff && (issued_nxt < target) && (inflight_nxt < INF_MAX));
                seq_done_nxt = finish;
            end
            KSEQ_DRAIN: seq_done_nxt = finish;
            default: ;
        endcase
        if (state_nxt == KSEQ_FAULT) begin
            start_nxt    = 1'b0;
            seq_done_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            start_q    <= 1'b0;
            seq_done_q <= 1'b0;
            target     <= '0;
            issued_q   <= '0;
            done_q     <= '0;
            inflight_q <= '0;
            abort_q    <= 1'b0;
            to_cnt     <= '0;
        end else begin
            start_q    <= start_nxt;
            seq_done_q <= seq_done_nxt;
            if (accept) begin
                target     <= cmd_runs;
                issued_q   <= '0;
                done_q     <= '0;
                inflight_q <= '0;
                abort_q    <= 1'b0;
                to_cnt     <= '0;
            end else if (live && state_nxt != KSEQ_FAULT) begin
                issued_q   <= issued_nxt;
                done_q     <= done_nxt;
                inflight_q <= inflight_nxt;
                abort_q    <= abort_q || (abort && state == KSEQ_RUN);
                to_cnt     <= (dn || inflight_q == '0) ? '0 : to_cnt + LAT_W'(1);
            end
        end
    end

    assign ap.ap_start = start_q;
    assign cmd_ready   = (state == KSEQ_IDLE);
    assign seq_busy    = (state != KSEQ_IDLE);
    assign seq_error   = (state == KSEQ_FAULT);
    assign seq_done    = seq_done_q;
    assign runs_issued = issued_q;
    assign runs_done   = done_q;
    assign inflight    = inflight_q;

`ifdef KERNEL_SEQ_LAT_STATS_EN
    logic [LAT_W-1:0]      now_q, pend_stamp, head, last_q, max_q, lat;
    logic [KSEQ_INF_W-1:0] fcount;
    logic                  valid_done, bypass, fifo_push, fifo_pop;

    // A non-pipelined kernel raises ready and done together with nothing queued, so the
    // stamp of the current start is used directly instead of round-tripping the FIFO.
    always_comb begin
        valid_done = dn && live && !spurious;
        bypass     = valid_done && hs && (fcount == '0);
        fifo_pop   = valid_done && !bypass;
        fifo_push  = hs && !bypass;
        lat        = now_q - (bypass ? pend_stamp : head);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            now_q      <= '0;
            pend_stamp <= '0;
            last_q     <= '0;
            max_q      <= '0;
        end else begin
            now_q <= now_q + LAT_W'(1);
            if (start_nxt && (!start_q || hs))
                pend_stamp <= now_q + LAT_W'(1);
            if (valid_done)
                last_q <= lat;
            if (accept)
                max_q <= '0;
            else if (valid_done && lat > max_q)
                max_q <= lat;
        end
    end

    kernel_seq_ts_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .W     (LAT_W)
    ) u_ts_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (pend_stamp),
        .dout  (head),
        .count (fcount)
    );

    assign last_lat = last_q;
    assign max_lat  = max_q;
`else
    assign last_lat = '0;
    assign max_lat  = '0;
`endif

endmodule

// File: tb/tb_kernel_run_sequencer.sv
// tb/tb_kernel_run_sequencer.sv - scoreboard bench for kernel_run_sequencer with a behavioural ap_ctrl_hs kernel
module tb_kernel_run_sequencer;

    localparam int CNT_W = 16;
    localparam int LAT_W = 24;

    typedef struct {
        int cyc;
        int issued;
        int done;
        int last;
        int mx;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] cmd_runs = '0;
    logic             cmd_ready, seq_busy, seq_done, seq_error;
    logic [CNT_W-1:0] runs_issued, runs_done;
    logic [3:0]       inflight;
    logic [LAT_W-1:0] last_lat, max_lat;

    kernel_run_sequencer_if kif();

    kernel_run_sequencer #(
        .CNT_W          (CNT_W),
        .MAX_INFLIGHT   (2),
        .LAT_W          (LAT_W),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_runs    (cmd_runs),
        .abort       (abort),
        .ap          (kif),
        .seq_busy    (seq_busy),
        .seq_done    (seq_done),
        .seq_error   (seq_error),
        .runs_issued (runs_issued),
        .runs_done   (runs_done),
        .inflight    (inflight),
        .last_lat    (last_lat),
        .max_lat     (max_lat)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    int total = 0;
    int bad = 0;
    exp_t exp_q[$];
    int   err_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int lat(input int x);
`ifdef KERNEL_SEQ_LAT_STATS_EN
        return x;
`else
        return 0;
`endif
    endfunction

    // Kernel model: ready after ready_dly cycles of a held start, done done_dly after start rose.
    int  ready_dly = 1, done_dly = 1, done_keep = 1000, hs_given = 0, hs_total = 0;
    int  age = 0, start_cyc = 0;
    bit  prev_start = 0, prev_hs = 0, force_done = 0;
    bit  m_r, m_d;
    int  done_at[$];

    always begin
        @(negedge clock);
        #1;
        if (kif.ap_start === 1'b1) begin
            if (!prev_start || prev_hs) begin
                age = 0;
                start_cyc = cyc;
            end else begin
                age++;
            end
        end
        m_r = (kif.ap_start === 1'b1) && (age == ready_dly);
        if (m_r) begin
            hs_total++;
            if (hs_given < done_keep) done_at.push_back(start_cyc + done_dly);
            hs_given++;
        end
        m_d = 1'b0;
        if (done_at.size() > 0 && done_at[0] == cyc) begin
            void'(done_at.pop_front());
            m_d = 1'b1;
        end
        kif.ap_ready = m_r;
        kif.ap_done  = m_d | force_done;
        kif.ap_idle  = (done_at.size() == 0) && !((kif.ap_start === 1'b1) && !m_r);
        prev_start   = (kif.ap_start === 1'b1);
        prev_hs      = m_r;
    end

    int peak = 0;
    bit prev_err = 0;
    bit rdy_chk = 0;
    exp_t e;
    int   ec;

    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (int'(inflight) > peak) peak = int'(inflight);
            if (rdy_chk) begin
                chk("cmd_ready_after_done", int'(cmd_ready), 1);
                rdy_chk = 0;
            end
            if (seq_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_seq_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("seq_done_cycle", cyc, e.cyc);
                    chk("runs_issued", int'(runs_issued), e.issued);
                    chk("runs_done", int'(runs_done), e.done);
                    chk("last_lat", int'(last_lat), e.last);
                    chk("max_lat", int'(max_lat), e.mx);
                    chk("busy_at_done", int'(seq_busy), 1);
                    rdy_chk = 1;
                end
            end
            if (seq_error === 1'b1 && !prev_err) begin
                if (err_q.size() == 0) begin
                    chk("unexpected_seq_error", 1, 0);
                end else begin
                    ec = err_q.pop_front();
                    chk("seq_error_cycle", cyc, ec);
                end
            end
        end
        prev_err = (seq_error === 1'b1);
    end

    task automatic issue(input int runs, input int rd, input int dd, input int keep, output int acc);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk("cmd_ready_wait", int'(cmd_ready), 1);
        ready_dly = rd;
        done_dly  = dd;
        done_keep = keep;
        hs_given  = 0;
        cmd_runs  = CNT_W'(runs);
        cmd_valid = 1'b1;
        acc       = cyc;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock);
        chk("done_wait_left", exp_q.size(), 0);
        repeat (2) @(negedge clock);
    endtask

    task automatic wait_err(input int budget);
        for (int i = 0; i < budget && err_q.size() != 0; i++) @(negedge clock);
        chk("error_wait_left", err_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "bench timeout");
    end

    initial begin
        int a, hs0, st0, ones;
        kif.ap_ready = 1'b0;
        kif.ap_done  = 1'b0;
        kif.ap_idle  = 1'b1;
        repeat (3) @(negedge clock);

        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_ap_start", int'(kif.ap_start), 0);
        chk("rst_busy", int'(seq_busy), 0);
        chk("rst_done", int'(seq_done), 0);
        chk("rst_error", int'(seq_error), 0);
        chk("rst_issued", int'(runs_issued), 0);
        chk("rst_runs_done", int'(runs_done), 0);
        chk("rst_inflight", int'(inflight), 0);
        chk("rst_last_lat", int'(last_lat), 0);
        chk("rst_max_lat", int'(max_lat), 0);
        reset = 1'b1;

        // single run, non-pipelined kernel
        issue(1, 10, 10, 1000, a);
        exp_q.push_back(exp_t'{a + 12, 1, 1, lat(10), lat(10)});
        wait_done(100);

        // five pipelined runs, at most two in flight
        issue(5, 1, 6, 1000, a);
        exp_q.push_back(exp_t'{a + 22, 5, 5, lat(6), lat(6)});
        wait_done(100);
        chk("inflight_peak", peak, 2);

        // zero-run command
        hs0 = hs_total;
        st0 = 0;
        issue(0, 1, 1, 1000, a);
        exp_q.push_back(exp_t'{a + 2, 0, 0, lat(6), 0});
        wait_done(20);
        chk("zero_run_handshakes", hs_total - hs0, st0);

        // abort pulse while the first start waits for ready
        hs0 = hs_total;
        issue(10, 3, 3, 1000, a);
        @(negedge clock);
        chk("start_high_at_abort", int'(kif.ap_start), 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        exp_q.push_back(exp_t'{a + 5, 1, 1, lat(3), lat(3)});
        wait_done(50);
        chk("abort_handshakes", hs_total - hs0, 1);

        // second run never completes: watchdog fault 51 cycles after the last done
        issue(2, 1, 6, 1, a);
        err_q.push_back(a + 58);
        wait_err(200);
        ones = 0;
        repeat (20) begin
            @(negedge clock);
            ones += int'(seq_error);
        end
        chk("error_sticky", ones, 20);
        chk("fault_cmd_ready", int'(cmd_ready), 0);
        chk("fault_ap_start", int'(kif.ap_start), 0);

        reset = 1'b0;
        @(negedge clock);
        chk("reset_clears_error", int'(seq_error), 0);
        chk("reset_cmd_ready", int'(cmd_ready), 1);
        done_at.delete();
        prev_start = 0;
        prev_hs = 0;
        reset = 1'b1;
        @(negedge clock);

        // spurious done while idle
        err_q.push_back(cyc + 1);
        force_done = 1'b1;
        @(negedge clock);
        force_done = 1'b0;
        wait_err(20);
        @(negedge clock);
        chk("spurious_cmd_ready", int'(cmd_ready), 0);

        chk("handshakes_total", hs_total, 9);
        chk("exp_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
